// File: rtl/decode_pipe.sv
// Handshaked instruction decode stage: one-cycle field decode into registered outputs,
// with an optional 2-entry skid buffer that keeps in_ready off the combinational path.
module decode_pipe #(
  parameter int INST_W  = 16,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-9:0] out_imm,
  output logic [1:0]        out_type,
  output logic [2:0]        out_subtype,
  output logic [2:0]        out_wr_addr,
  output logic [2:0]        out_rx_addr,
  output logic [2:0]        out_alu_op,
  output logic              out_alu_imm,
  output logic [1:0]        out_special,
  output logic              out_illegal
);
  localparam int IMM_W = INST_W - 8;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic [1:0]       typ;
    logic [2:0]       subtype;
    logic [2:0]       wr_addr;
    logic [2:0]       rx_addr;
    logic [2:0]       alu_op;
    logic             alu_imm;
    logic [1:0]       special;
    logic             illegal;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  dec_t       dec, main_q, skid_q;
  state_t     state, state_n;
  logic [1:0] typ;
  logic [2:0] sub, rx;
  logic       accept, drain, load_in, load_skid, shift;

  assign typ = in_inst[1:0];
  assign sub = in_inst[4:2];
  assign rx  = in_inst[7:5];

  always_comb begin
    dec         = '0;
    dec.imm     = in_inst[INST_W-1:8];
    dec.typ     = typ;
    dec.subtype = sub;
    dec.alu_op  = sub;
    dec.alu_imm = (typ == 2'b11);
    if (typ == 2'b10 || (typ == 2'b01 && sub == 3'b000)) dec.wr_addr = rx;
    if ((typ == 2'b01 && sub != 3'b000) || typ == 2'b10)  dec.rx_addr = rx;
    if (typ == 2'b00 && sub == 3'b111) begin
      case (rx)
        3'b000:  dec.special = 2'b01;
        3'b001:  dec.special = 2'b10;
        3'b111:  dec.special = 2'b11;
        default: begin
          dec.special = 2'b01;
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

  // flush masks both handshakes so nothing moves in the flush cycle
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) state <= EMPTY;
    else            state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load_in   = 1'b0;
    load_skid = 1'b0;
    shift     = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_n = ONE;
          load_in = 1'b1;
        end
        ONE: begin
          case ({accept, drain})
            2'b10: begin
              state_n   = TWO;
              load_skid = 1'b1;
            end
            2'b01: state_n = EMPTY;
            2'b11: load_in = 1'b1;
            default: ;
          endcase
        end
        TWO: if (drain) begin
          state_n = ONE;
          shift   = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_in)    main_q <= dec;
      else if (shift) main_q <= skid_q;
      if (load_skid)  skid_q <= dec;
    end
  end

  generate
    if (SKID_EN) begin : gen_skid
      logic rdy_q;
      always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) rdy_q <= 1'b0;
        else            rdy_q <= (state_n != TWO);
      end
      assign in_ready = rdy_q;
    end else begin : gen_flat
      // live holds in_ready low through reset and for the release cycle
      logic live;
      always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) live <= 1'b0;
        else            live <= 1'b1;
      end
      assign in_ready = live & (~out_valid | out_ready);
    end
  endgenerate

  assign out_imm     = main_q.imm;
  assign out_type    = main_q.typ;
  assign out_subtype = main_q.subtype;
  assign out_wr_addr = main_q.wr_addr;
  assign out_rx_addr = main_q.rx_addr;
  assign out_alu_op  = main_q.alu_op;
  assign out_alu_imm = main_q.alu_imm;
  assign out_special = main_q.special;
  assign out_illegal = main_q.illegal;
endmodule
